// File: rtl/common.sv
// rtl/common.sv - machine-wide scalar types shared by the pipeline
package common;

    typedef logic [63:0] word_t;
    typedef logic [63:0] addr_t;
    typedef logic [7:0]  strobe_t;

    // Encoded as log2 of the access width in bytes
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

endpackage

// File: rtl/pipes.sv
// rtl/pipes.sv - inter-stage bundles, MEM state encoding and op helpers
package pipes;
    import common::*;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_LB  = 4'd2,
        OP_LH  = 4'd3,
        OP_LW  = 4'd4,
        OP_LD  = 4'd5,
        OP_LBU = 4'd6,
        OP_LHU = 4'd7,
        OP_LWU = 4'd8,
        OP_SB  = 4'd9,
        OP_SH  = 4'd10,
        OP_SW  = 4'd11,
        OP_SD  = 4'd12
    } op_t;

    typedef struct packed {
        op_t        op;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic [4:0] dst;
    } execute_ctl_t;

    typedef struct packed {
        addr_t        pc;
        logic [31:0]  instruction;
        word_t        result;
        word_t        memdata;
        execute_ctl_t ctl;
    } execute_data_t;

    typedef struct packed {
        op_t        op;
        logic       regwrite;
        logic [4:0] dst;
    } memory_ctl_t;

    typedef struct packed {
        addr_t       pc;
        logic [31:0] instruction;
        word_t       result;
        memory_ctl_t ctl;
    } memory_data_t;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t S_IDLE = 2'd0;
    localparam mem_state_t S_REQ  = 2'd1;
    localparam mem_state_t S_DATA = 2'd2;

    function automatic msize_t op_size(op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return MSIZE1;
            OP_LH, OP_LHU, OP_SH: return MSIZE2;
            OP_LW, OP_LWU, OP_SW: return MSIZE4;
            default:              return MSIZE8;
        endcase
    endfunction

    function automatic logic op_is_store(op_t op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane steering for stores and extension for loads
module mem_align
    import common::*;
    import pipes::*;
(
    input  op_t         op,
    input  logic [2:0]  addr,
    input  word_t       memdata,
    input  word_t       dresp_data,
    output msize_t      size,
    output strobe_t     strobe,
    output word_t       store_data,
    output word_t       load_data,
    output logic        misalign
);

    logic [5:0] shamt;
    word_t      raw;

    assign size       = op_size(op);
    assign shamt      = {addr, 3'b000};
    assign store_data = memdata << shamt;
    assign raw        = dresp_data >> shamt;

    always_comb begin
        strobe   = '0;
        misalign = 1'b0;
        case (size)
            MSIZE1: strobe = 8'h01 << addr;
            MSIZE2: begin
                strobe   = 8'h03 << addr;
                misalign = addr[0];
            end
            MSIZE4: begin
                strobe   = 8'h0f << addr;
                misalign = |addr[1:0];
            end
            default: begin
                strobe   = 8'hff << addr;
                misalign = |addr;
            end
        endcase
        // Loads never assert byte enables
        if (!op_is_store(op)) begin
            strobe = '0;
        end
    end

    always_comb begin
        load_data = raw;
        case (op)
            OP_LB:   load_data = {{56{raw[7]}},  raw[7:0]};
            OP_LH:   load_data = {{48{raw[15]}}, raw[15:0]};
            OP_LW:   load_data = {{32{raw[31]}}, raw[31:0]};
            OP_LBU:  load_data = {56'd0, raw[7:0]};
            OP_LHU:  load_data = {48'd0, raw[15:0]};
            OP_LWU:  load_data = {32'd0, raw[31:0]};
            default: load_data = raw;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM stage: data-bus FSM, cur latch and output register
module memory_stage
    import common::*;
    import pipes::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  execute_data_t dataE,
    output logic          in_ready,
    output logic          out_valid,
    output memory_data_t  dataM,
    output logic          out_misalign,
    output logic          dreq_valid,
    output logic          dreq_write,
    output addr_t         dreq_addr,
    output msize_t        dreq_size,
    output strobe_t       dreq_strobe,
    output word_t         dreq_data,
    input  logic          dresp_addr_ok,
    input  logic          dresp_data_ok,
    input  word_t         dresp_data
);

    mem_state_t    state;
    execute_data_t cur;
    memory_data_t  pass_e;
    memory_data_t  done_c;

    logic       idle;
    logic       is_mem;
    logic       complete;
    op_t        al_op;
    logic [2:0] al_off;
    word_t      al_memdata;
    msize_t     al_size;
    strobe_t    al_strobe;
    word_t      al_store;
    word_t      al_load;
    logic       al_mis;

    assign idle   = (state == S_IDLE);
    assign is_mem = dataE.ctl.memread | dataE.ctl.memwrite;

    // In S_IDLE the aligner looks at the incoming op to flag misalignment;
    // once a request is in flight it looks only at cur.
    assign al_op      = idle ? dataE.ctl.op      : cur.ctl.op;
    assign al_off     = idle ? dataE.result[2:0] : cur.result[2:0];
    assign al_memdata = idle ? dataE.memdata     : cur.memdata;

    mem_align u_align (
        .op         (al_op),
        .addr       (al_off),
        .memdata    (al_memdata),
        .dresp_data (dresp_data),
        .size       (al_size),
        .strobe     (al_strobe),
        .store_data (al_store),
        .load_data  (al_load),
        .misalign   (al_mis)
    );

    assign in_ready    = idle;
    assign dreq_valid  = (state == S_REQ);
    assign dreq_write  = cur.ctl.memwrite;
    assign dreq_addr   = cur.result;
    assign dreq_size   = al_size;
    assign dreq_strobe = (state == S_REQ) ? al_strobe : '0;
    assign dreq_data   = al_store;

    assign complete = ((state == S_REQ) && dresp_addr_ok && dresp_data_ok) ||
                      ((state == S_DATA) && dresp_data_ok);

    // pass_e serves both ALU pass-through and misaligned rejects, which never write back
    always_comb begin
        pass_e              = '0;
        pass_e.pc           = dataE.pc;
        pass_e.instruction  = dataE.instruction;
        pass_e.result       = dataE.result;
        pass_e.ctl.op       = dataE.ctl.op;
        pass_e.ctl.regwrite = dataE.ctl.regwrite & ~is_mem;
        pass_e.ctl.dst      = dataE.ctl.dst;
    end

    always_comb begin
        done_c              = '0;
        done_c.pc           = cur.pc;
        done_c.instruction  = cur.instruction;
        done_c.result       = cur.ctl.memread ? al_load : cur.result;
        done_c.ctl.op       = cur.ctl.op;
        done_c.ctl.regwrite = cur.ctl.memread & cur.ctl.regwrite;
        done_c.ctl.dst      = cur.ctl.dst;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            cur          <= '0;
            dataM        <= '0;
            out_valid    <= 1'b0;
            out_misalign <= 1'b0;
        end else begin
            out_valid    <= 1'b0;
            out_misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!is_mem) begin
                            out_valid <= 1'b1;
                            dataM     <= pass_e;
                        end else begin
                            cur <= dataE;
                            if (al_mis) begin
                                out_valid    <= 1'b1;
                                out_misalign <= 1'b1;
                                dataM        <= pass_e;
                            end else begin
                                state <= S_REQ;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (dresp_addr_ok) begin
                        state <= dresp_data_ok ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (dresp_data_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (complete) begin
                out_valid <= 1'b1;
                dataM     <= done_c;
            end
        end
    end

endmodule
